// File: rtl/lrpt_viterbi_pkg.sv
// Shared types, constants and encoder model for the LRPT K=7 rate-1/2 Viterbi decoder.
package lrpt_viterbi_pkg;

    localparam int NUM_STATES = 64;
    localparam int K          = 7;
    localparam int BM_W       = 18;
    localparam int PM_W       = 24;

    localparam logic [6:0] POLY_A = 7'b1111001;
    localparam logic [6:0] POLY_B = 7'b1011011;

    typedef logic [PM_W-1:0] pm_t;
    typedef logic [BM_W-1:0] bm_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } acs_state_t;

    // Encoder register is {in_bit, ps}; MSB of the result comes from POLY_A.
    function automatic logic [1:0] exp_out(input logic in_bit, input logic [5:0] ps);
        logic [6:0] enc;
        enc = {in_bit, ps};
        return {^(enc & POLY_A), ^(enc & POLY_B)};
    endfunction

endpackage

// File: rtl/acs_pmu_butterfly.sv
// One radix-2 add-compare-select butterfly with saturating adders; ties favour the even predecessor.
module acs_butterfly
    import lrpt_viterbi_pkg::*;
(
    input  logic [PM_W-1:0] pm_even,
    input  logic [PM_W-1:0] pm_odd,
    input  logic [BM_W-1:0] bm_a,
    input  logic [BM_W-1:0] bm_b,
    output logic [PM_W-1:0] pm_lo,
    output logic [PM_W-1:0] pm_hi,
    output logic            dec_lo,
    output logic            dec_hi,
    output logic            sat
);
    localparam int SW = PM_W + 1;

    logic [SW-1:0]   lo_e, lo_o, hi_e, hi_o;
    logic [PM_W-1:0] lo_e_c, lo_o_c, hi_e_c, hi_o_c;

    // bm_a labels the even->low and odd->high branches, bm_b the other two.
    assign lo_e = {1'b0, pm_even} + SW'(bm_a);
    assign lo_o = {1'b0, pm_odd}  + SW'(bm_b);
    assign hi_e = {1'b0, pm_even} + SW'(bm_b);
    assign hi_o = {1'b0, pm_odd}  + SW'(bm_a);

    assign lo_e_c = lo_e[PM_W] ? '1 : lo_e[PM_W-1:0];
    assign lo_o_c = lo_o[PM_W] ? '1 : lo_o[PM_W-1:0];
    assign hi_e_c = hi_e[PM_W] ? '1 : hi_e[PM_W-1:0];
    assign hi_o_c = hi_o[PM_W] ? '1 : hi_o[PM_W-1:0];

    assign dec_lo = (lo_o_c < lo_e_c);
    assign dec_hi = (hi_o_c < hi_e_c);
    assign pm_lo  = dec_lo ? lo_o_c : lo_e_c;
    assign pm_hi  = dec_hi ? hi_o_c : hi_e_c;

    assign sat = (dec_lo ? lo_o[PM_W] : lo_e[PM_W]) | (dec_hi ? hi_o[PM_W] : hi_e[PM_W]);

endmodule

// File: rtl/acs_pmu.sv
// Serial ACS / path-metric unit: one butterfly per cycle, 64-bit decision word per symbol.
// Optional best_state output is built when ACS_BEST_STATE_EN is defined.
module acs_pmu
    import lrpt_viterbi_pkg::*;
(
    input  logic            clk,
    input  logic            sys_rst_n,
    input  logic            bm_valid,
    output logic            bm_ready,
    input  logic [BM_W-1:0] bm_00,
    input  logic [BM_W-1:0] bm_01,
    input  logic [BM_W-1:0] bm_10,
    input  logic [BM_W-1:0] bm_11,
    output logic            dec_valid,
    output logic [63:0]     dec_out,
    output logic            ovf_flag
`ifdef ACS_BEST_STATE_EN
    ,
    output logic [5:0]      best_state
`endif
);
    localparam pm_t PM_INIT = pm_t'(1) << (PM_W - 2);

    acs_state_t state_reg;
    logic [4:0] k_reg;
    logic       bank_sel_reg;
    pm_t        pm_reg [2][NUM_STATES];
    pm_t        min_prev_reg;
    pm_t        min_run_reg;
    logic [63:0] dec_acc_reg;
    bm_t        bm_reg [4];

    logic [5:0] ps_even, ps_odd;
    logic [1:0] sel_a, sel_b;
    pm_t        pm_e_raw, pm_o_raw, pm_e_norm, pm_o_norm;
    pm_t        pm_lo, pm_hi, cyc_min;
    logic       dec_lo, dec_hi, sat;

    assign ps_even = {k_reg, 1'b0};
    assign ps_odd  = {k_reg, 1'b1};

    // Both generators tap the input bit and ps[0], so only two labels per butterfly are distinct.
    assign sel_a = exp_out(1'b0, ps_even);
    assign sel_b = exp_out(1'b0, ps_odd);

    assign pm_e_raw  = pm_reg[bank_sel_reg][ps_even];
    assign pm_o_raw  = pm_reg[bank_sel_reg][ps_odd];
    assign pm_e_norm = (pm_e_raw > min_prev_reg) ? pm_e_raw - min_prev_reg : '0;
    assign pm_o_norm = (pm_o_raw > min_prev_reg) ? pm_o_raw - min_prev_reg : '0;

    acs_butterfly u_bfly (
        .pm_even (pm_e_norm),
        .pm_odd  (pm_o_norm),
        .bm_a    (bm_reg[sel_a]),
        .bm_b    (bm_reg[sel_b]),
        .pm_lo   (pm_lo),
        .pm_hi   (pm_hi),
        .dec_lo  (dec_lo),
        .dec_hi  (dec_hi),
        .sat     (sat)
    );

    assign cyc_min = (pm_lo <= pm_hi) ? pm_lo : pm_hi;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg    <= IDLE;
            k_reg        <= '0;
            bank_sel_reg <= 1'b0;
            min_prev_reg <= '0;
            min_run_reg  <= '0;
            dec_acc_reg  <= '0;
            bm_ready     <= 1'b1;
            dec_valid    <= 1'b0;
            dec_out      <= '0;
            ovf_flag     <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int s = 0; s < NUM_STATES; s++) begin
                    pm_reg[b][s] <= (b == 0 && s == 0) ? '0 : PM_INIT;
                end
            end
            for (int i = 0; i < 4; i++) begin
                bm_reg[i] <= '0;
            end
        end else begin
            dec_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bm_valid && bm_ready) begin
                        bm_reg[0] <= bm_00;
                        bm_reg[1] <= bm_01;
                        bm_reg[2] <= bm_10;
                        bm_reg[3] <= bm_11;
                        k_reg     <= '0;
                        bm_ready  <= 1'b0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    pm_reg[~bank_sel_reg][{1'b0, k_reg}] <= pm_lo;
                    pm_reg[~bank_sel_reg][{1'b1, k_reg}] <= pm_hi;
                    dec_acc_reg[{1'b0, k_reg}] <= dec_lo;
                    dec_acc_reg[{1'b1, k_reg}] <= dec_hi;
                    if (sat) begin
                        ovf_flag <= 1'b1;
                    end
                    if (k_reg == 5'd0 || cyc_min < min_run_reg) begin
                        min_run_reg <= cyc_min;
                    end
                    k_reg <= k_reg + 5'd1;
                    if (k_reg == 5'd31) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    bank_sel_reg <= ~bank_sel_reg;
                    min_prev_reg <= min_run_reg;
                    dec_out      <= dec_acc_reg;
                    dec_valid    <= 1'b1;
                    bm_ready     <= 1'b1;
                    state_reg    <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    bm_ready  <= 1'b1;
                end
            endcase
        end
    end

`ifdef ACS_BEST_STATE_EN
    logic [5:0] cyc_idx;
    logic [5:0] best_run_reg;

    assign cyc_idx = (pm_lo <= pm_hi) ? {1'b0, k_reg} : {1'b1, k_reg};

    // States arrive as 0,32,1,33,..., so an equal metric must still compare indices.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            best_run_reg <= '0;
            best_state   <= '0;
        end else if (state_reg == RUN) begin
            if (k_reg == 5'd0 || cyc_min < min_run_reg ||
                (cyc_min == min_run_reg && cyc_idx < best_run_reg)) begin
                best_run_reg <= cyc_idx;
            end
        end else if (state_reg == DONE) begin
            best_state <= best_run_reg;
        end
    end
`endif

endmodule

// File: tb/tb_acs_pmu.sv
// Directed self-checking bench for acs_pmu (best_state checks follow ACS_BEST_STATE_EN).
module tb_acs_pmu;
    import lrpt_viterbi_pkg::*;

    localparam logic [PM_W-1:0] PM_START = 24'h400000;
    localparam logic [BM_W-1:0] BM_MAX   = 18'h3FFFF;

    logic            clk = 1'b0;
    logic            sys_rst_n = 1'b0;
    logic            bm_valid = 1'b0;
    logic            bm_ready;
    logic [BM_W-1:0] bm_00 = '0, bm_01 = '0, bm_10 = '0, bm_11 = '0;
    logic            dec_valid;
    logic [63:0]     dec_out;
    logic            ovf_flag;
`ifdef ACS_BEST_STATE_EN
    logic [5:0]      best_state;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    acs_pmu dut (
        .clk        (clk),
        .sys_rst_n  (sys_rst_n),
        .bm_valid   (bm_valid),
        .bm_ready   (bm_ready),
        .bm_00      (bm_00),
        .bm_01      (bm_01),
        .bm_10      (bm_10),
        .bm_11      (bm_11),
        .dec_valid  (dec_valid),
        .dec_out    (dec_out),
        .ovf_flag   (ovf_flag)
`ifdef ACS_BEST_STATE_EN
        ,
        .best_state (best_state)
`endif
    );

    task automatic do_reset();
        bm_valid  = 1'b0;
        sys_rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        sys_rst_n = 1'b1;
    endtask

    // Offers one metric set, then waits (bounded) for dec_valid; lat=-1 means it never came.
    task automatic send_symbol(input logic [BM_W-1:0] a00, input logic [BM_W-1:0] a01,
                               input logic [BM_W-1:0] a10, input logic [BM_W-1:0] a11,
                               output int lat, output logic [63:0] dec, output logic [5:0] bs);
        int guard;
        @(negedge clk);
        bm_00 = a00; bm_01 = a01; bm_10 = a10; bm_11 = a11;
        bm_valid = 1'b1;
        guard = 0;
        while (!bm_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 bm_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (dec_valid) begin
                lat = n;
                break;
            end
        end
        dec = dec_out;
`ifdef ACS_BEST_STATE_EN
        bs = best_state;
`else
        bs = 6'd0;
`endif
        $display("sym bm=%0d/%0d/%0d/%0d lat=%0d dec_out=%016h best=%0d", a00, a01, a10, a11, lat, dec, bs);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (bm_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", bm_ready); end
        checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL reset_dec_valid got=%b want=0", dec_valid); end
        checks++; if (dec_out !== 64'h0) begin failures++; $display("FAIL reset_dec_out got=%h want=0", dec_out); end
        checks++; if (ovf_flag !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", ovf_flag); end
`ifdef ACS_BEST_STATE_EN
        checks++; if (best_state !== 6'd0) begin failures++; $display("FAIL reset_best got=%0d want=0", best_state); end
`endif
    endtask

    task automatic test_zero_symbol();
        int lat; logic [63:0] dec; logic [5:0] bs;
        do_reset();
        send_symbol('0, '0, '0, '0, lat, dec, bs);
        checks++; if (lat !== 33) begin failures++; $display("FAIL zero_latency got=%0d want=33", lat); end
        checks++; if (dec !== 64'h0) begin failures++; $display("FAIL zero_dec got=%h want=0", dec); end
        checks++; if (dut.pm_reg[1][0] !== 24'd0) begin failures++; $display("FAIL zero_pm0 got=%0d want=0", dut.pm_reg[1][0]); end
        checks++; if (dut.pm_reg[1][32] !== 24'd0) begin failures++; $display("FAIL zero_pm32 got=%0d want=0", dut.pm_reg[1][32]); end
        checks++; if (dut.pm_reg[1][1] !== PM_START) begin failures++; $display("FAIL zero_pm1 got=%0d want=%0d", dut.pm_reg[1][1], PM_START); end
        checks++; if (dut.pm_reg[1][63] !== PM_START) begin failures++; $display("FAIL zero_pm63 got=%0d want=%0d", dut.pm_reg[1][63], PM_START); end
        @(posedge clk); #1;
        checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL zero_pulse got=%b want=0", dec_valid); end
    endtask

    task automatic test_zero_codeword();
        int lat; logic [63:0] dec; logic [5:0] bs;
        do_reset();
        for (int s = 0; s < 10; s++) begin
            send_symbol('0, 18'd100, 18'd100, 18'd100, lat, dec, bs);
            checks++; if (lat !== 33) begin failures++; $display("FAIL zcw_latency sym=%0d got=%0d want=33", s, lat); end
            checks++; if (dec[0] !== 1'b0) begin failures++; $display("FAIL zcw_dec0 sym=%0d got=%b want=0", s, dec[0]); end
`ifdef ACS_BEST_STATE_EN
            checks++; if (bs !== 6'd0) begin failures++; $display("FAIL zcw_best sym=%0d got=%0d want=0", s, bs); end
`endif
            if (s == 0) begin
                checks++; if (dut.min_prev_reg !== 24'd0) begin failures++; $display("FAIL zcw_min_prev got=%0d want=0", dut.min_prev_reg); end
            end
        end
        checks++; if (dut.pm_reg[0][0] !== 24'd0) begin failures++; $display("FAIL zcw_pm0 got=%0d want=0", dut.pm_reg[0][0]); end
    endtask

    task automatic test_path();
        logic [1:0] outs [7];
        int         path [7];
        logic       dbit [7];
        logic [BM_W-1:0] m [4];
        int lat; logic [63:0] dec; logic [5:0] bs;
        // Input bits 1,0,1,1,0,0,0 from state 0 through the K=7 encoder.
        outs = '{2'b11, 2'b10, 2'b00, 2'b10, 2'b01, 2'b01, 2'b00};
        path = '{32, 16, 40, 52, 26, 13, 6};
        dbit = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int s = 0; s < 7; s++) begin
            for (int h = 0; h < 4; h++) m[h] = (outs[s] == h[1:0]) ? 18'd0 : 18'd50;
            send_symbol(m[0], m[1], m[2], m[3], lat, dec, bs);
            checks++; if (lat !== 33) begin failures++; $display("FAIL path_latency sym=%0d got=%0d want=33", s, lat); end
            checks++; if (dec[path[s]] !== dbit[s]) begin failures++; $display("FAIL path_dec sym=%0d state=%0d got=%b want=%b", s, path[s], dec[path[s]], dbit[s]); end
`ifdef ACS_BEST_STATE_EN
            checks++; if (bs !== 6'(path[s])) begin failures++; $display("FAIL path_best sym=%0d got=%0d want=%0d", s, bs, path[s]); end
`endif
        end
    endtask

    task automatic test_back_to_back();
        int ready_hi = 0, bad_pos = 0, dv = 0;
        logic [63:0] first_dec = '1;
        do_reset();
        @(negedge clk);
        bm_00 = '0; bm_01 = '0; bm_10 = '0; bm_11 = '0;
        bm_valid = 1'b1;
        @(posedge clk);
        #1;
        bm_01 = 18'd100; bm_10 = 18'd100; bm_11 = 18'd100;
        for (int c = 1; c <= 102; c++) begin
            @(posedge clk);
            #1;
            if (bm_ready) begin
                ready_hi++;
                if (c % 34 != 33) bad_pos++;
            end
            if (dec_valid) begin
                dv++;
                if (c % 34 != 33) bad_pos++;
                if (c == 33) first_dec = dec_out;
            end
        end
        bm_valid = 1'b0;
        $display("b2b ready_cycles=%0d dec_pulses=%0d misplaced=%0d first_dec=%016h", ready_hi, dv, bad_pos, first_dec);
        checks++; if (ready_hi != 3) begin failures++; $display("FAIL b2b_accepts got=%0d want=3", ready_hi); end
        checks++; if (dv != 3) begin failures++; $display("FAIL b2b_dec_pulses got=%0d want=3", dv); end
        checks++; if (bad_pos != 0) begin failures++; $display("FAIL b2b_timing misplaced=%0d want=0", bad_pos); end
        checks++; if (first_dec !== 64'h0) begin failures++; $display("FAIL b2b_midrun_bm got=%h want=0", first_dec); end
        repeat (40) @(posedge clk);
    endtask

    task automatic test_reset_mid_run();
        int lat, dv; logic [63:0] dec; logic [5:0] bs;
        do_reset();
        send_symbol('0, 18'd100, 18'd100, 18'd100, lat, dec, bs);
        checks++; if (dec[4] !== 1'b1) begin failures++; $display("FAIL mid_pre_dec4 got=%b want=1", dec[4]); end
        @(negedge clk);
        bm_00 = '0; bm_01 = '0; bm_10 = '0; bm_11 = '0;
        bm_valid = 1'b1;
        @(posedge clk);
        #1 bm_valid = 1'b0;
        repeat (15) @(posedge clk);
        #2 sys_rst_n = 1'b0;
        #1;
        $display("mid_run_reset ready=%b dec_valid=%b dec_out=%016h ovf=%b", bm_ready, dec_valid, dec_out, ovf_flag);
        checks++; if (bm_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b want=1", bm_ready); end
        checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL mid_dec_valid got=%b want=0", dec_valid); end
        checks++; if (dec_out !== 64'h0) begin failures++; $display("FAIL mid_dec_out got=%h want=0", dec_out); end
        checks++; if (ovf_flag !== 1'b0) begin failures++; $display("FAIL mid_ovf got=%b want=0", ovf_flag); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        sys_rst_n = 1'b1;
        dv = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (dec_valid) dv++;
        end
        checks++; if (dv != 0) begin failures++; $display("FAIL mid_no_pulse got=%0d want=0", dv); end
        send_symbol('0, '0, '0, '0, lat, dec, bs);
        checks++; if (lat !== 33) begin failures++; $display("FAIL mid_next_latency got=%0d want=33", lat); end
        checks++; if (dec !== 64'h0) begin failures++; $display("FAIL mid_next_dec got=%h want=0", dec); end
        checks++; if (dut.pm_reg[1][1] !== PM_START) begin failures++; $display("FAIL mid_next_pm1 got=%0d want=%0d", dut.pm_reg[1][1], PM_START); end
    endtask

    task automatic test_saturation();
        int lat, bad_lat; logic [63:0] dec; logic [5:0] bs;
        do_reset();
        bad_lat = 0;
        for (int s = 0; s < 200; s++) begin
            send_symbol(BM_MAX, BM_MAX, BM_MAX, BM_MAX, lat, dec, bs);
            if (lat != 33) bad_lat++;
            if (s == 0) begin
                checks++; if (dut.min_prev_reg !== 24'(BM_MAX)) begin failures++; $display("FAIL sat_min_first got=%0d want=%0d", dut.min_prev_reg, BM_MAX); end
            end
        end
        checks++; if (bad_lat != 0) begin failures++; $display("FAIL sat_latency bad=%0d want=0", bad_lat); end
        checks++; if (ovf_flag !== 1'b0) begin failures++; $display("FAIL sat_ovf got=%b want=0", ovf_flag); end
        checks++; if (dut.min_prev_reg !== 24'(BM_MAX)) begin failures++; $display("FAIL sat_min_last got=%0d want=%0d", dut.min_prev_reg, BM_MAX); end
    endtask

    initial begin
        test_reset();
        test_zero_symbol();
        test_zero_codeword();
        test_path();
        test_back_to_back();
        test_reset_mid_run();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
